// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the four-channel round-robin select arbiter.
// State encoding, channel/index widths and the one-hot to index encoder.
package rr_arb_pkg;

  localparam int NUM_CH = 4;
  localparam int IDX_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Lowest set bit wins; callers only pass one-hot or zero vectors.
  function automatic logic [IDX_W-1:0] encode(input logic [NUM_CH-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_prio_pick4.sv
// Combinational rotating-priority picker: returns the first requesting channel
// found when scanning from ptr upward, wrapping modulo four.
module rr_prio_pick4
  import rr_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              any,
  output logic [IDX_W-1:0]  idx
);

  logic [IDX_W-1:0] cand;

  // Scan farthest offset first so the nearest requester overwrites the result.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter4.sv
// Round-robin arbiter driving the select of a downstream 4:1 mux.
// Optional forced release after MAX_HOLD busy cycles when HOLD_TIMEOUT_EN is defined.
module rr_sel_arbiter4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              done,
  output logic [NUM_CH-1:0] grant,
  output logic              gnt_valid,
  output logic              s1,
  output logic              s0,
  output logic              timeout
);

  if ((1 << CNT_W) <= MAX_HOLD || MAX_HOLD < 1) begin : g_bad_hold_cfg
    $error("rr_sel_arbiter4: MAX_HOLD must be >= 1 and fit in CNT_W bits");
  end

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gidx;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             norm_rel;
  logic             force_rel;
  logic             release_any;

  rr_prio_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign gidx     = {s1, s0};
  assign norm_rel = done | ~req[gidx];

`ifdef HOLD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt;

  // The edge ending the MAX_HOLD-th busy cycle forces release unless the owner lets go itself.
  assign force_rel = (state == BUSY) && (hold_cnt == HOLD_LAST) && !norm_rel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= force_rel;
      if (state == BUSY) hold_cnt <= hold_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      else               hold_cnt <= '0;
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign release_any = norm_rel | force_rel;

  // Select bits are left untouched on release so the mux input stays stable while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      gnt_valid <= 1'b0;
      s1        <= 1'b0;
      s0        <= 1'b0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= BUSY;
            grant     <= NUM_CH'(1) << pick_idx;
            gnt_valid <= 1'b1;
            {s1, s0}  <= pick_idx;
          end
        end
        BUSY: begin
          if (release_any) begin
            state     <= IDLE;
            grant     <= '0;
            gnt_valid <= 1'b0;
            ptr       <= encode(grant) + IDX_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          grant     <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Directed bench for rr_sel_arbiter4: reset, rotation, skip/wrap, release by drop,
// mid-grant reset and hold-limit behaviour (both with and without HOLD_TIMEOUT_EN).
module tb_rr_sel_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       gnt_valid;
  logic       s1;
  logic       s0;
  logic       timeout;

  int vec_count = 0;
  int err_count = 0;

  rr_sel_arbiter4 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .gnt_valid (gnt_valid),
    .s1        (s1),
    .s0        (s0),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkGrant(input string tag, input logic [3:0] exp_gnt, input logic exp_gv,
                            input logic [1:0] exp_sel, input logic exp_to);
    checkOutput({tag, ".grant"}, {4'b0, grant}, {4'b0, exp_gnt});
    checkOutput({tag, ".gnt_valid"}, {7'b0, gnt_valid}, {7'b0, exp_gv});
    checkOutput({tag, ".sel"}, {6'b0, s1, s0}, {6'b0, exp_sel});
    checkOutput({tag, ".timeout"}, {7'b0, timeout}, {7'b0, exp_to});
  endtask

  // Drive inputs 1ns after a rising edge, then advance to 1ns after the next one.
  task automatic applyStimulus(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;
    #2;
    checkGrant("reset_async", 4'b0000, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;
    checkGrant("reset_held", 4'b0000, 1'b0, 2'b00, 1'b0);
    rst = 1'b0;

    applyStimulus(4'b1111, 1'b0);
    checkGrant("rot_g0", 4'b0001, 1'b1, 2'b00, 1'b0);
    applyStimulus(4'b1111, 1'b1);
    checkGrant("rot_idle0", 4'b0000, 1'b0, 2'b00, 1'b0);
    applyStimulus(4'b1111, 1'b0);
    checkGrant("rot_g1", 4'b0010, 1'b1, 2'b01, 1'b0);
    applyStimulus(4'b1111, 1'b1);
    checkGrant("rot_idle1", 4'b0000, 1'b0, 2'b01, 1'b0);
    applyStimulus(4'b1111, 1'b0);
    checkGrant("rot_g2", 4'b0100, 1'b1, 2'b10, 1'b0);
    applyStimulus(4'b1111, 1'b1);
    applyStimulus(4'b1111, 1'b0);
    checkGrant("rot_g3", 4'b1000, 1'b1, 2'b11, 1'b0);
    applyStimulus(4'b1111, 1'b1);
    checkGrant("rot_idle3", 4'b0000, 1'b0, 2'b11, 1'b0);
    applyStimulus(4'b1111, 1'b0);
    checkGrant("rot_wrap", 4'b0001, 1'b1, 2'b00, 1'b0);

    // ch0 released by dropping its request, ptr -> 1; only ch2 asks next.
    applyStimulus(4'b0100, 1'b0);
    checkGrant("drop0_idle", 4'b0000, 1'b0, 2'b00, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    checkGrant("g2", 4'b0100, 1'b1, 2'b10, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkGrant("drop2_idle", 4'b0000, 1'b0, 2'b10, 1'b0);
    applyStimulus(4'b0011, 1'b0);
    checkGrant("skip_wrap_g0", 4'b0001, 1'b1, 2'b00, 1'b0);
    applyStimulus(4'b0011, 1'b1);
    applyStimulus(4'b0011, 1'b0);
    checkGrant("skip_wrap_g1", 4'b0010, 1'b1, 2'b01, 1'b0);

    // Other channels requesting while busy must not disturb the grant.
    applyStimulus(4'b1111, 1'b0);
    checkGrant("busy_ignore", 4'b0010, 1'b1, 2'b01, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkGrant("done_idle", 4'b0000, 1'b0, 2'b01, 1'b0);
    applyStimulus(4'b1111, 1'b0);
    checkGrant("ptr_after_drop", 4'b0100, 1'b1, 2'b10, 1'b0);

    #3 rst = 1'b1;
    #1;
    checkGrant("mid_reset", 4'b0000, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b0);
    checkGrant("post_reset_g0", 4'b0001, 1'b1, 2'b00, 1'b0);

    // ch0 done -> ptr=1; ch1 then holds its request without ever finishing.
    applyStimulus(4'b0010, 1'b1);
    applyStimulus(4'b0110, 1'b0);
    checkGrant("hold_g1", 4'b0010, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 14; i++) applyStimulus(4'b0110, 1'b0);
    checkGrant("hold_15th", 4'b0010, 1'b1, 2'b01, 1'b0);
    applyStimulus(4'b0110, 1'b0);
`ifdef HOLD_TIMEOUT_EN
    checkGrant("forced_rel", 4'b0000, 1'b0, 2'b01, 1'b1);
    applyStimulus(4'b0110, 1'b0);
    checkGrant("after_to_g2", 4'b0100, 1'b1, 2'b10, 1'b0);
    for (int i = 0; i < 14; i++) applyStimulus(4'b0110, 1'b0);
    applyStimulus(4'b0110, 1'b1);
    checkGrant("norm_at_limit", 4'b0000, 1'b0, 2'b10, 1'b0);
    applyStimulus(4'b0110, 1'b0);
    checkGrant("after_norm_g1", 4'b0010, 1'b1, 2'b01, 1'b0);
`else
    checkGrant("no_timeout16", 4'b0010, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(4'b0110, 1'b0);
    checkGrant("no_timeout24", 4'b0010, 1'b1, 2'b01, 1'b0);
    applyStimulus(4'b0110, 1'b1);
    applyStimulus(4'b0110, 1'b0);
    checkGrant("after_hold_g2", 4'b0100, 1'b1, 2'b10, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
